// File: rtl/result_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : result_tx_scheduler
// Brief    : Per-channel result queue with round-robin grant, sequential
//            double-dabble to ASCII decimal, and byte streaming to SPI master.
// Revision : 1.0 - initial release
// ============================================================================
module result_tx_scheduler #(
  parameter int         CHANNEL_COUNT  = 3,
  parameter int         RESULT_WIDTH   = 32,
  parameter int         SLAVE_COUNT    = 3,
  parameter bit         SUPPRESS_ZEROS = 1'b1,
  parameter logic [7:0] TERMINATOR     = 8'h0A
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [CHANNEL_COUNT*RESULT_WIDTH-1:0] result_in,
  input  logic [CHANNEL_COUNT-1:0]              result_valid,
  input  logic                                  spi_ready,
  output logic [7:0]                            tx_byte,
  output logic                                  tx_byte_valid,
  output logic [SLAVE_COUNT-1:0]                ss_out,
  output logic [CHANNEL_COUNT-1:0]              pending,
  output logic                                  busy
);

  localparam int c_digits = (RESULT_WIDTH * 301) / 1000 + 1;
  localparam int c_bcd_w  = c_digits * 4;
  localparam int c_ch_w   = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
  localparam int c_idx_w  = (c_digits > 1) ? $clog2(c_digits) : 1;
  localparam int c_cnt_w  = $clog2(RESULT_WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(RESULT_WIDTH - 1);
  localparam logic [c_idx_w-1:0] c_idx_top  = c_idx_w'(c_digits - 1);
  localparam logic [c_ch_w-1:0]  c_ch_last  = c_ch_w'(CHANNEL_COUNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_SKIP    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  state_t                     r_state, w_state_next;
  logic [RESULT_WIDTH-1:0]    r_hold [CHANNEL_COUNT];
  logic [CHANNEL_COUNT-1:0]   r_pending;
  logic [c_ch_w-1:0]          r_ptr;
  logic [RESULT_WIDTH-1:0]    r_bin;
  logic [c_bcd_w-1:0]         r_bcd;
  logic [c_cnt_w-1:0]         r_cnt;
  logic [c_idx_w-1:0]         r_idx;
  logic                       r_term;
  logic                       r_fin;
  logic [7:0]                 r_tx_byte;
  logic                       r_tx_valid;
  logic [SLAVE_COUNT-1:0]     r_ss;

  logic                       w_grant, w_send, w_found;
  logic [c_ch_w-1:0]          w_gidx, w_scan;
  logic [CHANNEL_COUNT-1:0]   w_clr;
  logic [c_idx_w-1:0]         w_msd;
  logic [c_bcd_w-1:0]         w_adj;
  logic [3:0]                 w_nib;

  function automatic logic [c_bcd_w-1:0] f_add3(input logic [c_bcd_w-1:0] bcd);
    logic [c_bcd_w-1:0] v;
    v = bcd;
    for (int d = 0; d < c_digits; d++)
      if (v[d*4 +: 4] >= 4'd5) v[d*4 +: 4] = v[d*4 +: 4] + 4'd3;
    return v;
  endfunction

  assign w_adj = f_add3(r_bcd);
  assign w_nib = r_bcd[{r_idx, 2'b00} +: 4];
  assign w_clr = w_grant ? (CHANNEL_COUNT'(1) << w_gidx) : '0;

  // First pending channel at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_scan  = '0;
    for (int k = 0; k < CHANNEL_COUNT; k++) begin
      w_scan = c_ch_w'((int'(r_ptr) + k) % CHANNEL_COUNT);
      if (!w_found && r_pending[w_scan]) begin
        w_found = 1'b1;
        w_gidx  = w_scan;
      end
    end
  end

  // Highest non-zero nibble; an all-zero value still sends digit 0.
  always_comb begin
    w_msd = '0;
    for (int d = 0; d < c_digits; d++)
      if (r_bcd[d*4 +: 4] != 4'd0) w_msd = c_idx_w'(d);
    if (!SUPPRESS_ZEROS) w_msd = c_idx_top;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_send       = 1'b0;
    case (r_state)
      ST_IDLE:
        if (w_found) begin
          w_grant      = 1'b1;
          w_state_next = ST_CONVERT;
        end
      ST_CONVERT: if (r_cnt == c_cnt_last) w_state_next = ST_SKIP;
      ST_SKIP:    w_state_next = ST_WAIT;
      ST_WAIT:
        if (spi_ready) begin
          w_send       = 1'b1;
          w_state_next = ST_HOLD;
        end
      ST_HOLD:    w_state_next = r_fin ? ST_IDLE : ST_WAIT;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNEL_COUNT; i++)
        if (result_valid[i]) r_hold[i] <= result_in[i*RESULT_WIDTH +: RESULT_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending  <= '0;
      r_ptr      <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_term     <= 1'b0;
      r_fin      <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_ss       <= '0;
    end else begin
      // A strobe coinciding with the grant keeps the channel pending.
      r_pending <= (r_pending & ~w_clr) | result_valid;
      case (r_state)
        ST_IDLE:
          if (w_grant) begin
            r_bin  <= r_hold[w_gidx];
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_term <= 1'b0;
            r_fin  <= 1'b0;
            r_ptr  <= (w_gidx == c_ch_last) ? '0 : w_gidx + 1'b1;
            r_ss   <= SLAVE_COUNT'(1) << w_gidx;
          end
        ST_CONVERT: begin
          r_bcd <= {w_adj[c_bcd_w-2:0], r_bin[RESULT_WIDTH-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_SKIP: r_idx <= w_msd;
        ST_WAIT:
          if (w_send) begin
            r_tx_valid <= 1'b1;
            r_tx_byte  <= r_term ? TERMINATOR : {4'h3, w_nib};
            if (r_term)             r_fin  <= 1'b1;
            else if (r_idx == '0)   r_term <= 1'b1;
            else                    r_idx  <= r_idx - 1'b1;
          end
        ST_HOLD: begin
          r_tx_valid <= 1'b0;
          if (r_fin) r_ss <= '0;
        end
        default: ;
      endcase
    end
  end

  assign tx_byte       = r_tx_byte;
  assign tx_byte_valid = r_tx_valid;
  assign ss_out        = r_ss;
  assign pending       = r_pending;
  assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_result_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_tx_scheduler
// Brief    : Directed and randomized checks against a decimal-string and
//            round-robin reference model; two DUTs (zero suppression on/off).
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_tx_scheduler;

  localparam int CH = 3;
  localparam int W  = 32;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH*W-1:0] result_in = '0;
  logic [CH-1:0] result_valid = '0;
  logic          spi_ready = 1'b1;
  logic          ready_cmd = 1'b1;
  logic          rnd_ready = 1'b0;

  logic [7:0]    tx_byte, tx_byte2;
  logic          tx_byte_valid, tx_byte_valid2;
  logic [2:0]    ss_out, ss_out2;
  logic [CH-1:0] pending, pending2;
  logic          busy, busy2;

  result_tx_scheduler #(.CHANNEL_COUNT(CH), .RESULT_WIDTH(W), .SLAVE_COUNT(3),
                        .SUPPRESS_ZEROS(1'b1), .TERMINATOR(8'h0A)) dut (
    .clk(clk), .reset(reset), .result_in(result_in), .result_valid(result_valid),
    .spi_ready(spi_ready), .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid),
    .ss_out(ss_out), .pending(pending), .busy(busy));

  result_tx_scheduler #(.CHANNEL_COUNT(CH), .RESULT_WIDTH(W), .SLAVE_COUNT(3),
                        .SUPPRESS_ZEROS(1'b0), .TERMINATOR(8'h0A)) dut_nz (
    .clk(clk), .reset(reset), .result_in(result_in), .result_valid(result_valid),
    .spi_ready(spi_ready), .tx_byte(tx_byte2), .tx_byte_valid(tx_byte_valid2),
    .ss_out(ss_out2), .pending(pending2), .busy(busy2));

  always #5 clk = ~clk;

  always @(negedge clk)
    spi_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_cyc   = 0;
  int          m_ptr   = 0;
  logic [10:0] q1[$], q2[$];
  int          qc[$];
  int          g_cyc = 0;
  logic [2:0]  g_pend = '0;
  logic [2:0]  prev_ss = '0;

  // Byte/slave-select capture and grant detection.
  always @(negedge clk) begin
    n_cyc++;
    if (tx_byte_valid) begin
      q1.push_back({ss_out, tx_byte});
      qc.push_back(n_cyc);
    end
    if (tx_byte_valid2) q2.push_back({ss_out2, tx_byte2});
    if (ss_out != 3'b000 && prev_ss == 3'b000) begin
      g_cyc  = n_cyc;
      g_pend = pending;
    end
    prev_ss = ss_out;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t exp_bytes(input logic [31:0] v, input bit sup);
    bq_t    m;
    longint x;
    int     n;
    x = longint'(v);
    n = 0;
    do begin
      m.push_front(8'h30 + 8'(x % 10));
      x = x / 10;
      n++;
    end while (x != 0);
    if (!sup) while (n < 10) begin m.push_front(8'h30); n++; end
    m.push_back(8'h0A);
    return m;
  endfunction

  task automatic expect_msg(input string tag, input int ch, input logic [31:0] v);
    bq_t        e1, e2;
    logic [2:0] ssx;
    e1  = exp_bytes(v, 1'b1);
    e2  = exp_bytes(v, 1'b0);
    ssx = 3'b001 << ch;
    foreach (e1[i])
      chk($sformatf("%s_sup_b%0d", tag, i), (q1.size() > 0) ? 64'(q1.pop_front()) : 64'hx, {ssx, e1[i]});
    foreach (e2[i])
      chk($sformatf("%s_full_b%0d", tag, i), (q2.size() > 0) ? 64'(q2.pop_front()) : 64'hx, {ssx, e2[i]});
    m_ptr = (ch + 1) % CH;
  endtask

  task automatic strobe(input logic [2:0] mask, input logic [31:0] v0, v1, v2);
    @(negedge clk);
    result_in    = {v2, v1, v0};
    result_valid = mask;
    @(negedge clk);
    result_valid = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end
    while ((busy || busy2 || pending != 0 || pending2 != 0) && k < budget);
    chk({tag, "_idle"}, {busy, busy2, pending, pending2}, '0);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (q1.size() < n && k < budget) begin @(negedge clk); k++; end
    chk({tag, "_bytes_seen"}, 64'(q1.size() >= n), 64'd1);
  endtask

  task automatic run_round(input string tag, input logic [2:0] mask,
                           input logic [31:0] v0, v1, v2, input int budget);
    logic [31:0] vals [CH];
    int          start;
    vals[0] = v0; vals[1] = v1; vals[2] = v2;
    q1.delete(); q2.delete(); qc.delete();
    strobe(mask, v0, v1, v2);
    wait_idle(tag, budget);
    start = m_ptr;
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (start + k) % CH;
      if (mask[c]) expect_msg($sformatf("%s_ch%0d", tag, c), c, vals[c]);
    end
    chk({tag, "_leftover"}, 64'(q1.size() + q2.size()), 64'd0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
    q1.delete(); q2.delete(); qc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       held_ok;
    logic [2:0] rmask;
    logic [31:0] rv [CH];

    repeat (3) @(negedge clk);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_valid", tx_byte_valid, 1'b0);
    chk("rst_ss", ss_out, 3'b000);
    chk("rst_pending", pending, 3'b000);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // ch1 = 21: bytes, slave select, grant-to-strobe latency, pending clear
    run_round("ch1_21", 3'b010, 32'd0, 32'd21, 32'd0, 1000);
    chk("ch1_latency", (qc.size() > 0) ? 64'(qc[0] - g_cyc) : 64'hx, 64'd34);
    chk("ch1_pend_at_grant", g_pend, 3'b000);

    run_round("zero", 3'b001, 32'd0, 32'd0, 32'd0, 1000);
    run_round("full", 3'b001, 32'hFFFF_FFFF, 32'd0, 32'd0, 1000);

    // Fresh pointer: simultaneous strobes served ch0, ch1, ch2, then wrap
    reset_pulse();
    run_round("all3", 3'b111, 32'd7, 32'd8, 32'd9, 2000);
    run_round("wrap", 3'b001, 32'd11, 32'd0, 32'd0, 1000);

    // Re-strobe of the channel being sent
    q1.delete(); q2.delete();
    strobe(3'b100, 32'd0, 32'd0, 32'd123);
    wait_bytes("restrobe", 1, 200);
    strobe(3'b100, 32'd0, 32'd0, 32'd5);
    chk("restrobe_pending", {pending[2], pending2[2]}, 2'b11);
    chk("restrobe_busy", {busy, busy2}, 2'b11);
    wait_idle("restrobe", 2000);
    expect_msg("restrobe_123", 2, 32'd123);
    expect_msg("restrobe_5", 2, 32'd5);
    chk("restrobe_leftover", 64'(q1.size() + q2.size()), 64'd0);

    // spi_ready held low: nothing sent, select held
    ready_cmd = 1'b0;
    q1.delete(); q2.delete();
    strobe(3'b010, 32'd0, 32'd6502, 32'd0);
    repeat (40) @(negedge clk);
    held_ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (ss_out !== 3'b010 || ss_out2 !== 3'b010) held_ok = 1'b0;
    end
    chk("ready_low_no_strobe", 64'(q1.size() + q2.size()), 64'd0);
    chk("ready_low_ss_held", held_ok, 1'b1);
    chk("ready_low_busy", {busy, busy2}, 2'b11);
    ready_cmd = 1'b1;
    wait_idle("ready_low", 1000);
    expect_msg("ready_low_6502", 1, 32'd6502);
    chk("ready_low_leftover", 64'(q1.size() + q2.size()), 64'd0);

    // Randomized rounds with random spi_ready
    rnd_ready = 1'b1;
    for (int r = 0; r < 10; r++) begin
      rmask = 3'($urandom_range(1, 7));
      for (int c = 0; c < CH; c++) begin
        rv[c] = $urandom() >> $urandom_range(0, 31);
        if ($urandom_range(0, 7) == 0) rv[c] = 32'd0;
      end
      run_round($sformatf("rnd%0d", r), rmask, rv[0], rv[1], rv[2], 4000);
    end
    rnd_ready = 1'b0;

    // Asynchronous reset during the second digit
    q1.delete(); q2.delete();
    strobe(3'b001, 32'd4567, 32'd0, 32'd0);
    wait_bytes("arst", 1, 200);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_tx_byte", {tx_byte, tx_byte2}, 16'h0000);
    chk("arst_valid", {tx_byte_valid, tx_byte_valid2}, 2'b00);
    chk("arst_ss", {ss_out, ss_out2}, 6'b000000);
    chk("arst_pending", {pending, pending2}, 6'b000000);
    chk("arst_busy", {busy, busy2}, 2'b00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
    q1.delete(); q2.delete();
    repeat (100) @(negedge clk);
    chk("arst_no_residual", 64'(q1.size() + q2.size()), 64'd0);
    chk("arst_idle", {busy, busy2, pending, pending2}, 8'h00);
    run_round("post_rst", 3'b010, 32'd0, 32'd90, 32'd0, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
